// File: rtl/wb_commit_queue_pkg.sv
// Shared constants, the commit record layout and the write-back data resolver
// for the write-back commit queue.
package wb_commit_queue_pkg;

  // Write-back source selects. The W-stage register and the write-back mux
  // both decode these values.
  localparam logic [1:0] wb_sel_valE  = 2'd0;
  localparam logic [1:0] wb_sel_valM  = 2'd1;
  localparam logic [1:0] wb_sel_pc4   = 2'd2;
  localparam logic       reg_wen_no_w = 1'b0;

  // One retired instruction as seen by the trace consumer (135 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pre_pc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        jump;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

  // Pick the value the register file receives; select 3 carries no data.
  function automatic logic [31:0] resolve_wdata(
    input logic [1:0]  sel,
    input logic [31:0] pc,
    input logic [31:0] val_e,
    input logic [31:0] val_m
  );
    logic [31:0] res;
    case (sel)
      wb_sel_valE: res = val_e;
      wb_sel_valM: res = val_m;
      wb_sel_pc4:  res = pc + 32'd4;
      default:     res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_commit_queue_fifo.sv
// commit_fifo: show-ahead synchronous FIFO. Storage is a plain array with a
// registered read port; the read address is the post-edge read pointer so the
// head register always holds the entry that will be at the front next cycle.
module commit_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  head_reg;
  logic [CW-1:0] wr_ptr_reg;
  logic [CW-1:0] rd_ptr_reg;
  logic [CW-1:0] wr_ptr_next;
  logic [CW-1:0] rd_ptr_next;
  logic          do_wr;
  logic          do_rd;

  // The extra pointer MSB distinguishes full from empty after wrap.
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A write while full is only legal when the head leaves on the same edge.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Next pointer values, also used as the look-ahead read address.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (do_wr) wr_ptr_next = wr_ptr_reg + CW'(1);
    if (do_rd) rd_ptr_next = rd_ptr_reg + CW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Registered head read. When the slot being written is the next head (the
  // queue goes from empty to one entry), forward the incoming record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg <= '0;
    end else if (do_wr && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
      head_reg <= wr_data;
    end else begin
      head_reg <= mem[rd_ptr_next[AW-1:0]];
    end
  end

  assign rd_data = empty ? '0 : head_reg;

endmodule

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: turns W-stage retirements into commit records, buffers
// them and drains them over a valid/ready trace port. Also reports full to
// the hazard unit, flags dropped commits and counts drained records.
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          regW_o_commit,
  input  logic [31:0]   regW_o_pc,
  input  logic [31:0]   regW_o_instr,
  input  logic [31:0]   regW_o_pre_pc,
  input  logic          regW_o_wb_reg_wen,
  input  logic [4:0]    regW_o_wb_rd,
  input  logic [1:0]    regW_o_wb_valD_sel,
  input  logic [31:0]   regW_o_valE,
  input  logic [31:0]   regW_o_valM,
  input  logic          regW_branch_jump_o,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [31:0]   trace_pc,
  output logic [31:0]   trace_instr,
  output logic [31:0]   trace_pre_pc,
  output logic          trace_wen,
  output logic [4:0]    trace_rd,
  output logic [31:0]   trace_wdata,
  output logic          trace_jump,
  output logic          cq_full,
  output logic [CW-1:0] cq_count,
  output logic          cq_overflow,
  output logic [63:0]   instret
);

  commit_rec_t in_rec;
  commit_rec_t head_rec;
  logic [REC_W-1:0] head_bits;
  logic        fifo_empty;
  logic        deq;
  logic        wen_eff;
  logic        overflow_reg;
  logic [63:0] instret_reg;

  // Form the record; writes to x0 are reported as no write with zero data.
  always_comb begin
    in_rec        = '0;
    wen_eff       = (regW_o_wb_reg_wen != reg_wen_no_w) && (regW_o_wb_rd != 5'd0);
    in_rec.pc     = regW_o_pc;
    in_rec.instr  = regW_o_instr;
    in_rec.pre_pc = regW_o_pre_pc;
    in_rec.wen    = wen_eff;
    in_rec.rd     = regW_o_wb_rd;
    in_rec.wdata  = wen_eff ? resolve_wdata(regW_o_wb_valD_sel, regW_o_pc,
                                            regW_o_valE, regW_o_valM)
                            : 32'd0;
    in_rec.jump   = regW_branch_jump_o;
  end

  assign trace_valid = !fifo_empty;
  assign deq         = trace_valid && trace_ready;

  commit_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_commit_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (regW_o_commit),
    .wr_data (in_rec),
    .rd_en   (deq),
    .rd_data (head_bits),
    .empty   (fifo_empty),
    .full    (cq_full),
    .count   (cq_count)
  );

  assign head_rec     = commit_rec_t'(head_bits);
  assign trace_pc     = head_rec.pc;
  assign trace_instr  = head_rec.instr;
  assign trace_pre_pc = head_rec.pre_pc;
  assign trace_wen    = head_rec.wen;
  assign trace_rd     = head_rec.rd;
  assign trace_wdata  = head_rec.wdata;
  assign trace_jump   = head_rec.jump;

  // Sticky drop flag: a commit while full with no drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (regW_o_commit && cq_full && !deq) begin
      overflow_reg <= 1'b1;
    end
  end

  // Retired-instruction counter, one per drained record, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_reg <= 64'd0;
    end else if (deq) begin
      instret_reg <= instret_reg + 64'd1;
    end
  end

  assign cq_overflow = overflow_reg;
  assign instret     = instret_reg;

endmodule
